prio_intr_ctrl: RTL

PRIO_INTR_CTRL -- requirements
Module: prio_intr_ctrl

---
 rtl/prio_intr_ctrl_pkg.sv | 14 +
 rtl/prio_intr_ctrl_prio_encoder.sv | 23 ++
 rtl/prio_intr_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/prio_intr_ctrl_pkg.sv
// Shared types and default vector constants for the priority interrupt controller.
package prio_intr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK     = 2'd2,
    SERVICE = 2'd3
  } state_t;

  localparam logic [7:0] DEF_VEC_BASE   = 8'h08;
  localparam logic [7:0] DEF_VEC_STRIDE = 8'h08;

endpackage

// File: rtl/prio_intr_ctrl_prio_encoder.sv
// Fixed-priority selector: lowest set index wins, index 0 is highest priority.
module prio_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the last hit (lowest index) sticks.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_intr_ctrl.sv
// Edge-triggered, fixed-priority, non-nesting interrupt controller with an
// IDLE/REQ/ACK/SERVICE handshake towards the CPU.
module prio_intr_ctrl
  import prio_intr_ctrl_pkg::*;
#(
  parameter int                   NUM_IRQ    = 4,
  parameter int                   VEC_WIDTH  = 8,
  parameter logic [VEC_WIDTH-1:0] VEC_BASE   = VEC_WIDTH'(DEF_VEC_BASE),
  parameter logic [VEC_WIDTH-1:0] VEC_STRIDE = VEC_WIDTH'(DEF_VEC_STRIDE)
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic [NUM_IRQ-1:0]   irq_req,
  input  logic [NUM_IRQ-1:0]   irq_mask,
  input  logic                 int_en,
  input  logic                 inta,
  input  logic                 eoi,
  output logic                 intr,
  output logic [VEC_WIDTH-1:0] vector,
  output logic                 vector_valid,
  output logic [NUM_IRQ-1:0]   in_service
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_t               state, state_nxt;
  logic [NUM_IRQ-1:0]   req_q;
  logic [NUM_IRQ-1:0]   pending;
  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   eligible;
  logic [NUM_IRQ-1:0]   win_onehot;
  logic [NUM_IRQ-1:0]   clr;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_vld;
  logic                 ack_fire;
  logic                 eoi_fire;
  logic [VEC_WIDTH-1:0] vec_calc;

  assign rise       = irq_req & ~req_q;
  assign eligible   = pending & ~irq_mask;
  assign win_onehot = NUM_IRQ'(1) << win_idx;
  assign clr        = ack_fire ? win_onehot : '0;
  // Arithmetic is done at VEC_WIDTH so the result wraps naturally.
  assign vec_calc   = VEC_BASE + VEC_WIDTH'(win_idx) * VEC_STRIDE;

  prio_encoder #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_prio (
    .req   (eligible),
    .idx   (win_idx),
    .valid (win_vld)
  );

  always_ff @(posedge clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_fire  = 1'b0;
    eoi_fire  = 1'b0;
    case (state)
      IDLE:    if (int_en && win_vld) state_nxt = REQ;
      REQ: begin
        if (!int_en || !win_vld) begin
          state_nxt = IDLE;
        end else if (inta) begin
          state_nxt = ACK;
          ack_fire  = 1'b1;
        end
      end
      ACK:     state_nxt = SERVICE;
      SERVICE: begin
        if (eoi) begin
          state_nxt = IDLE;
          eoi_fire  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A fresh edge on the line being acknowledged re-arms it (set wins).
  always_ff @(posedge clk) begin
    if (Rst) begin
      req_q        <= '0;
      pending      <= '0;
      intr         <= 1'b0;
      vector       <= '0;
      vector_valid <= 1'b0;
      in_service   <= '0;
    end else begin
      req_q        <= irq_req;
      pending      <= (pending & ~clr) | rise;
      intr         <= (state_nxt == REQ);
      vector_valid <= ack_fire;
      if (ack_fire) begin
        vector     <= vec_calc;
        in_service <= win_onehot;
      end else if (eoi_fire) begin
        in_service <= '0;
      end
    end
  end

endmodule
